// File: rtl/snake_wr_if.sv
// Cell-write port between the Snake game engine and the VGA renderer.
interface snake_wr_if;
  localparam int unsigned CW = 7;

  logic          i_Wr_Valid;
  logic [CW-1:0] i_Wr_Row;
  logic [CW-1:0] i_Wr_Col;
  logic          i_Wr_Data;
  logic          o_Wr_Ready;
  logic          o_Wr_Err;

  modport master (output i_Wr_Valid, i_Wr_Row, i_Wr_Col, i_Wr_Data,
                  input  o_Wr_Ready, o_Wr_Err);
  modport slave  (input  i_Wr_Valid, i_Wr_Row, i_Wr_Col, i_Wr_Data,
                  output o_Wr_Ready, o_Wr_Err);
endinterface

// File: rtl/snake_vga_renderer.sv
// Snake body bitmap (60x80 cells) with a clear sweep and write port, scanned
// out as a 640x480@60Hz VGA raster through a 2-stage pixel pipeline.
module snake_vga_renderer #(
  parameter int unsigned ROWS       = 60,
  parameter int unsigned COLS       = 80,
  parameter int unsigned CELL_SHIFT = 3,
  parameter int unsigned H_VIS      = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VIS      = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Clear,
  snake_wr_if.slave   wr,
  input  logic [6:0]  i_Head_Row,
  input  logic [6:0]  i_Head_Col,
  input  logic [6:0]  i_Item_Row,
  input  logic [6:0]  i_Item_Col,
  output logic        o_Hsync,
  output logic        o_Vsync,
  output logic [11:0] o_Rgb,
  output logic        o_Frame
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned CELLS   = ROWS * COLS;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned AW      = $clog2(CELLS);

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  state_t          state_q, state_n;
  logic [AW-1:0]   ptr_q, ptr_n;
  logic            ready_q, err_q, err_n;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic            mem_wdata;
  logic            accept, in_range;
  logic [AW-1:0]   wr_addr;
  logic            bitmap [CELLS];

  logic [HW-1:0]   h_q;
  logic [VW-1:0]   v_q;
  logic [6:0]      cell_row, cell_col;
  logic            vis;
  logic [AW-1:0]   rd_addr, rd_addr_q;
  logic            vis_q, head_hit_q, item_hit_q, hs_q, vs_q, frame_q;

  assign wr.o_Wr_Ready = ready_q;
  assign wr.o_Wr_Err   = err_q;

  assign accept   = wr.i_Wr_Valid && ready_q;
  assign in_range = (wr.i_Wr_Row != 7'd0) && (wr.i_Wr_Row <= 7'(ROWS)) &&
                    (wr.i_Wr_Col != 7'd0) && (wr.i_Wr_Col <= 7'(COLS));
  assign wr_addr  = AW'((32'(wr.i_Wr_Row) - 32'd1) * COLS + (32'(wr.i_Wr_Col) - 32'd1));

  // Sweep/idle control register; ready mirrors the next state so it is a flop
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      ready_q <= (state_n == ST_IDLE);
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    err_n     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = 1'b0;
    unique case (state_q)
      ST_SWEEP: begin
        mem_we = 1'b1;
        if (ptr_q == AW'(CELLS - 1)) begin
          state_n = ST_IDLE;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          err_n = !in_range;
          if (in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr.i_Wr_Data;
          end
        end
      end
    endcase
    // A clear request always (re)starts the sweep from address 0
    if (i_Clear) begin
      state_n = ST_SWEEP;
      ptr_n   = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (mem_we) bitmap[mem_waddr] <= mem_wdata;
  end

  // Raster position counters
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HW'(H_TOTAL - 1)) begin
      h_q <= '0;
      v_q <= (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
    end else begin
      h_q <= h_q + HW'(1);
    end
  end

  assign cell_row = 7'(v_q >> CELL_SHIFT) + 7'd1;
  assign cell_col = 7'(h_q >> CELL_SHIFT) + 7'd1;
  assign vis      = (h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS));
  assign rd_addr  = vis ? AW'(32'(v_q >> CELL_SHIFT) * COLS + 32'(h_q >> CELL_SHIFT)) : '0;

  // Stage 1 captures lookup address and compares; stage 2 resolves colour
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      rd_addr_q  <= '0;
      vis_q      <= 1'b0;
      head_hit_q <= 1'b0;
      item_hit_q <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      frame_q    <= 1'b0;
      o_Rgb      <= '0;
      o_Hsync    <= 1'b1;
      o_Vsync    <= 1'b1;
      o_Frame    <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr;
      vis_q      <= vis;
      head_hit_q <= (i_Head_Row == cell_row) && (i_Head_Col == cell_col);
      item_hit_q <= (i_Item_Row == cell_row) && (i_Item_Col == cell_col);
      hs_q       <= !((h_q >= HW'(H_VIS + H_FP)) && (h_q < HW'(H_VIS + H_FP + H_SYNC)));
      vs_q       <= !((v_q >= VW'(V_VIS + V_FP)) && (v_q < VW'(V_VIS + V_FP + V_SYNC)));
      frame_q    <= (v_q == VW'(V_VIS)) && (h_q == '0);
      o_Hsync    <= hs_q;
      o_Vsync    <= vs_q;
      o_Frame    <= frame_q;
      if (!vis_q)                o_Rgb <= 12'h000;
      else if (head_hit_q)       o_Rgb <= 12'h0F0;
      else if (item_hit_q)       o_Rgb <= 12'hF00;
      else if (bitmap[rd_addr_q]) o_Rgb <= 12'h080;
      else                       o_Rgb <= 12'h000;
    end
  end

endmodule

// File: tb/tb_snake_vga_renderer.sv
// Bench for snake_vga_renderer: directed phases with random writes/head/item,
// every cycle compared against a raster/bitmap reference model.
module tb_snake_vga_renderer;
  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Clear = 1'b0;
  logic [6:0]  head_row = '0, head_col = '0, item_row = '0, item_col = '0;
  logic        o_Hsync, o_Vsync, o_Frame;
  logic [11:0] o_Rgb;

  snake_wr_if wr();

  snake_vga_renderer dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clear    (i_Clear),
    .wr         (wr),
    .i_Head_Row (head_row),
    .i_Head_Col (head_col),
    .i_Item_Row (item_row),
    .i_Item_Col (item_col),
    .o_Hsync    (o_Hsync),
    .o_Vsync    (o_Vsync),
    .o_Rgb      (o_Rgb),
    .o_Frame    (o_Frame)
  );

  always #20 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;          // clock edges since reset release
  int left = 4800;      // sweep cycles still to go
  int left_prev = 4800;
  bit bm [1:60][1:80];
  logic [6:0] hist_hr [4], hist_hc [4], hist_ir [4], hist_ic [4];

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int p);
    int h = p % 800;
    int v = (p / 800) % 525;
    int k = p % 4;
    int r, c;
    if (h >= 640 || v >= 480) return 12'h000;
    r = v / 8 + 1;
    c = h / 8 + 1;
    if (32'(hist_hr[k]) == r && 32'(hist_hc[k]) == c) return 12'h0F0;
    if (32'(hist_ir[k]) == r && 32'(hist_ic[k]) == c) return 12'hF00;
    if (bm[r][c]) return 12'h080;
    return 12'h000;
  endfunction

  task automatic check_outputs(input bit exp_err);
    int p, h, v;
    if (cyc < 2) begin
      chk("rgb_rst", o_Rgb, 12'h000);
      chk("hsync_rst", 12'(o_Hsync), 12'h001);
      chk("vsync_rst", 12'(o_Vsync), 12'h001);
      chk("frame_rst", 12'(o_Frame), 12'h000);
    end else begin
      p = cyc - 2;
      h = p % 800;
      v = (p / 800) % 525;
      if ((left == 0 && left_prev == 0) || h >= 640 || v >= 480)
        chk("rgb", o_Rgb, model_rgb(p));
      chk("hsync", 12'(o_Hsync), 12'(!(h >= 656 && h < 752)));
      chk("vsync", 12'(o_Vsync), 12'(!(v >= 490 && v < 492)));
      chk("frame", 12'(o_Frame), 12'(v == 480 && h == 0));
    end
    chk("ready", 12'(wr.o_Wr_Ready), 12'(left == 0));
    chk("wr_err", 12'(wr.o_Wr_Err), 12'(exp_err));
  endtask

  // One clock: model the edge from the inputs of the ending cycle, then compare
  task automatic tick();
    bit acc, oor, done;
    int k;
    @(posedge i_Clk);
    k = cyc % 4;
    hist_hr[k] = head_row; hist_hc[k] = head_col;
    hist_ir[k] = item_row; hist_ic[k] = item_col;
    acc  = wr.i_Wr_Valid && (left == 0);
    oor  = (wr.i_Wr_Row == 0) || (wr.i_Wr_Row > 60) || (wr.i_Wr_Col == 0) || (wr.i_Wr_Col > 80);
    done = 1'b0;
    left_prev = left;
    if (i_Clear) left = 4800;
    else if (left > 0) begin
      left--;
      done = (left == 0);
    end
    #1;
    cyc++;
    check_outputs(acc && oor);
    if (acc && !oor) bm[wr.i_Wr_Row][wr.i_Wr_Col] = wr.i_Wr_Data;
    if (done) begin
      for (int r = 1; r <= 60; r++)
        for (int c = 1; c <= 80; c++) bm[r][c] = 1'b0;
    end
  endtask

  task automatic drive_wr(input int r, input int c, input bit d);
    wr.i_Wr_Valid = 1'b1;
    wr.i_Wr_Row = 7'(r);
    wr.i_Wr_Col = 7'(c);
    wr.i_Wr_Data = d;
    tick();
    wr.i_Wr_Valid = 1'b0;
    tick();
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    wr.i_Wr_Valid = 1'b0;
    wr.i_Wr_Row = '0;
    wr.i_Wr_Col = '0;
    wr.i_Wr_Data = 1'b0;

    // Reset values, then hold a valid write through the whole startup sweep
    repeat (3) @(posedge i_Clk);
    #5;
    check_outputs(1'b0);
    wr.i_Wr_Valid = 1'b1;
    wr.i_Wr_Row = 7'd2;
    wr.i_Wr_Col = 7'd3;
    wr.i_Wr_Data = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b1;
    cyc = 0; left = 4800; left_prev = 4800;
    while (left != 0) tick();
    tick();
    wr.i_Wr_Valid = 1'b0;

    // Out-of-range writes
    drive_wr(0, 3, 1'b1);
    drive_wr(61, 1, 1'b1);
    drive_wr(1, 81, 1'b1);
    drive_wr(1, 1, 1'b1);

    // Random writes and occasional head/item moves
    while (cyc < 24000) begin
      if ($urandom_range(0, 3) == 0) begin
        wr.i_Wr_Valid = 1'b1;
        wr.i_Wr_Row = 7'($urandom_range(0, 12));
        wr.i_Wr_Col = 7'($urandom_range(0, 84));
        wr.i_Wr_Data = 1'($urandom_range(0, 1));
      end else begin
        wr.i_Wr_Valid = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) begin
        head_row = 7'($urandom_range(0, 4)); head_col = 7'($urandom_range(0, 20));
        item_row = 7'($urandom_range(0, 4)); item_col = 7'($urandom_range(0, 20));
      end
      tick();
    end
    wr.i_Wr_Valid = 1'b0;

    // Colour priority on cell (5,5): head, then item, then body
    head_row = 7'd5; head_col = 7'd5;
    item_row = 7'd5; item_col = 7'd5;
    drive_wr(5, 5, 1'b1);
    run_until(800 * 34 + 2);
    head_row = '0; head_col = '0;
    run_until(800 * 36 + 2);
    item_row = '0; item_col = '0;
    run_until(800 * 40 + 2);

    // Fill cells, then clear twice 100 cycles apart mid-frame
    for (int i = 0; i < 10; i++) drive_wr(9 + (i % 3), 1 + 2 * i, 1'b1);
    run_until(40000);
    i_Clear = 1'b1; tick(); i_Clear = 1'b0;
    repeat (99) tick();
    i_Clear = 1'b1; tick(); i_Clear = 1'b0;
    while (left != 0) tick();
    while (cyc < 60000) begin
      wr.i_Wr_Valid = ($urandom_range(0, 7) == 0);
      wr.i_Wr_Row = 7'($urandom_range(9, 13));
      wr.i_Wr_Col = 7'($urandom_range(1, 82));
      wr.i_Wr_Data = 1'($urandom_range(0, 1));
      tick();
    end
    wr.i_Wr_Valid = 1'b0;

    // Asynchronous reset mid-frame, then a fresh sweep with writes pending
    i_Rst = 1'b0;
    #2;
    cyc = 0; left = 4800; left_prev = 4800;
    check_outputs(1'b0);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    while (cyc < 6000) begin
      wr.i_Wr_Valid = ($urandom_range(0, 3) == 0);
      wr.i_Wr_Row = 7'($urandom_range(0, 2));
      wr.i_Wr_Col = 7'($urandom_range(0, 82));
      wr.i_Wr_Data = 1'($urandom_range(0, 1));
      tick();
    end
    wr.i_Wr_Valid = 1'b0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
